// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares one register-file write port among NREQ writeback sources, plus a pending-write scoreboard.
// Latency: grant is combinational; the write reaches rf_we/rf_rd/rf_wd one cycle after the valid&ready transfer.
// Backpressure: only one requester gets ready per cycle and the others wait; the register file never stalls the output stage.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*4-1:0]    req_rd,
    input  logic [NREQ*32-1:0]   req_wd,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 sb_set,
    input  logic [3:0]           sb_set_rd,
    output logic [15:0]          pending,
    output logic                 rf_we,
    output logic [3:0]           rf_rd,
    output logic [31:0]          rf_wd,
    output logic [IDXW-1:0]      grant_idx
);

    logic [IDXW-1:0] ptr;
    logic [NREQ-1:0] gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            xfer;
    logic [3:0]      sel_rd;
    logic [31:0]     sel_wd;
    logic [15:0]     pending_nxt;
    logic [IDXW-1:0] cand;
    int              cand_sum;

    // Pick the first valid requester, starting the search at ptr and wrapping around.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        xfer     = 1'b0;
        cand     = '0;
        cand_sum = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum = int'(ptr) + k;
            if (cand_sum >= NREQ) begin
                cand_sum = cand_sum - NREQ;
            end
            cand = IDXW'(cand_sum);
            if (!xfer && req_valid[cand]) begin
                xfer      = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Mux the granted requester's destination and data out of the flat buses.
    always_comb begin
        sel_rd = '0;
        sel_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_rd = req_rd[i*4 +: 4];
                sel_wd = req_wd[i*32 +: 32];
            end
        end
    end

    // Scoreboard next state: clear the written register first so a same-cycle set (newer op) wins.
    always_comb begin
        pending_nxt = pending;
        if (xfer && (sel_rd != 4'd0)) begin
            pending_nxt[sel_rd] = 1'b0;
        end
        if (sb_set && (sb_set_rd != 4'd0)) begin
            pending_nxt[sb_set_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    assign req_ready = gnt;

    // Register the write port, the round-robin pointer and the scoreboard; r0 transfers are consumed silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we     <= 1'b0;
            rf_rd     <= '0;
            rf_wd     <= '0;
            ptr       <= '0;
            grant_idx <= '0;
            pending   <= '0;
        end else begin
            rf_we   <= xfer && (sel_rd != 4'd0);
            pending <= pending_nxt;
            if (xfer && (sel_rd != 4'd0)) begin
                rf_rd <= sel_rd;
                rf_wd <= sel_wd;
            end
            if (xfer) begin
                grant_idx <= gnt_idx;
                ptr       <= (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios followed by random traffic against a behavioural model.
// Latency: expectations are queued one per cycle and compared at the falling edge of that cycle.
// Backpressure: random requesters hold valid and payload until the model says they were granted.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int IDXW = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*4-1:0]    req_rd;
    logic [NREQ*32-1:0]   req_wd;
    logic [NREQ-1:0]      req_ready;
    logic                 sb_set;
    logic [3:0]           sb_set_rd;
    logic [15:0]          pending;
    logic                 rf_we;
    logic [3:0]           rf_rd;
    logic [31:0]          rf_wd;
    logic [IDXW-1:0]      grant_idx;

    regfile_wb_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_wd    (req_wd),
        .req_ready (req_ready),
        .sb_set    (sb_set),
        .sb_set_rd (sb_set_rd),
        .pending   (pending),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wd     (rf_wd),
        .grant_idx (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] rdy;
        logic            we;
        logic [3:0]      rd;
        logic [31:0]     wd;
        logic [15:0]     pend;
        logic [IDXW-1:0] gi;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state, in plain integers and bit arrays.
    int          m_ptr;
    int          m_gidx;
    bit          m_we;
    int          m_rd;
    logic [31:0] m_wd;
    bit [15:0]   m_pend;
    int          last_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_gidx = 0;
        m_we   = 0;
        m_rd   = 0;
        m_wd   = 32'd0;
        m_pend = '0;
        last_g = -1;
    endtask

    // Drive one cycle of inputs, queue what the DUT must show this cycle, then advance the model past the edge.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*4-1:0] rds,
                        input logic [NREQ*32-1:0] wds, input logic s, input logic [3:0] srd);
        exp_t e;
        int   g;
        int   j;
        int   grd;
        @(posedge clk);
        #1;
        req_valid = v;
        req_rd    = rds;
        req_wd    = wds;
        sb_set    = s;
        sb_set_rd = srd;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (g < 0 && v[j]) g = j;
        end
        e.rdy = '0;
        if (g >= 0) e.rdy[g] = 1'b1;
        e.we   = m_we;
        e.rd   = m_rd[3:0];
        e.wd   = m_wd;
        e.pend = m_pend;
        e.gi   = m_gidx[IDXW-1:0];
        exp_q.push_back(e);
        m_we = 0;
        if (g >= 0) begin
            m_ptr  = (g + 1) % NREQ;
            m_gidx = g;
            grd    = int'(rds[4*g +: 4]);
            if (grd != 0) begin
                m_we = 1;
                m_rd = grd;
                m_wd = wds[32*g +: 32];
                m_pend[grd] = 1'b0;
            end
        end
        if (s && srd != 4'd0) m_pend[srd] = 1'b1;
        last_g = g;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, 4'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_wd    = '0;
        sb_set    = 1'b0;
        sb_set_rd = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one queued expectation is compared against the DUT at every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("req_ready", 32'(req_ready), 32'(e.rdy));
                chk("rf_we",     32'(rf_we),     32'(e.we));
                chk("rf_rd",     32'(rf_rd),     32'(e.rd));
                chk("rf_wd",     rf_wd,          e.wd);
                chk("pending",   32'(pending),   32'(e.pend));
                chk("grant_idx", 32'(grant_idx), 32'(e.gi));
            end
        end
    end

    initial begin
        logic [NREQ-1:0]    v;
        logic [NREQ*4-1:0]  rds;
        logic [NREQ*32-1:0] wds;
        logic               s;
        logic [3:0]         srd;

        rst_n     = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_wd    = '0;
        sb_set    = 1'b0;
        sb_set_rd = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        idle(4);

        // Single requester write with a scoreboard entry set beforehand.
        step('0, '0, '0, 1'b1, 4'd5);
        idle(1);
        step(3'b001, {4'd0, 4'd0, 4'd5}, {32'd0, 32'd0, 32'hDEADBEEF}, 1'b0, 4'd0);
        idle(2);

        // All requesters continuously valid from reset: strict rotation.
        do_reset();
        for (int i = 0; i < 6; i++)
            step(3'b111, {4'd3, 4'd2, 4'd1}, {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001}, 1'b0, 4'd0);
        idle(2);

        // Same-cycle set and clear: same register, then different registers.
        step(3'b001, {4'd0, 4'd0, 4'd7}, {32'd0, 32'd0, 32'h7777_0007}, 1'b1, 4'd7);
        idle(1);
        step('0, '0, '0, 1'b1, 4'd8);
        step(3'b001, {4'd0, 4'd0, 4'd8}, {32'd0, 32'd0, 32'h8888_0008}, 1'b1, 4'd7);
        idle(2);

        // r0 write is accepted but dropped, and still advances the pointer.
        step(3'b010, {4'd0, 4'd0, 4'd0}, {32'd0, 32'h0000_1234, 32'd0}, 1'b0, 4'd0);
        step(3'b110, {4'd4, 4'd3, 4'd0}, {32'h4444_0004, 32'h3333_0003, 32'd0}, 1'b0, 4'd0);
        idle(2);

        // Asynchronous reset while a write is on the port.
        do_reset();
        for (int r = 4; r < 8; r++) step('0, '0, '0, 1'b1, 4'(r));
        step(3'b001, {4'd0, 4'd0, 4'd9}, {32'd0, 32'd0, 32'h9999_0009}, 1'b0, 4'd0);
        @(posedge clk);
        #2;
        chk("pre_reset_rf_we",   32'(rf_we),   32'd1);
        chk("pre_reset_pending", 32'(pending), 32'h0000_00F0);
        rst_n = 1'b0;
        #1;
        chk("async_rf_we",   32'(rf_we),   32'd0);
        chk("async_pending", 32'(pending), 32'd0);
        chk("async_rf_rd",   32'(rf_rd),   32'd0);
        req_valid = '0;
        req_rd    = '0;
        req_wd    = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b111, {4'd3, 4'd2, 4'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 4'd0);
        idle(2);

        // Random traffic; a waiting requester keeps its valid and payload until granted.
        v   = '0;
        rds = '0;
        wds = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(v[i] && last_g != i)) begin
                    v[i]            = ($urandom_range(0, 3) != 0);
                    rds[4*i +: 4]   = 4'($urandom_range(0, 15));
                    wds[32*i +: 32] = $urandom();
                end
            end
            s   = 1'($urandom_range(0, 1));
            srd = 4'($urandom_range(0, 15));
            step(v, rds, wds, s, srd);
        end
        idle(3);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
